// File: rtl/pattern_game_core.sv
// pattern_game_core: memory-game engine. Grows a pseudo-random symbol sequence one symbol per
// round, plays it out on a tick-paced display port, then checks player presses against it while
// keeping score and lives.
module pattern_game_core #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TICK_DIV      = 25000000,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int unsigned SYM_W        = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] user_in,
  output logic              disp_valid,
  output logic [SYM_W-1:0]  disp_sym,
  output logic [7:0]        score,
  output logic [3:0]        lives,
  output logic              busy,
  output logic              game_over,
  output logic              win
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW = $clog2(MAX_LEN);

  typedef enum logic [3:0] {
    StIdle, StExtend, StShowOn, StShowOff, StInput, StRoundOk, StMiss, StOver, StWin
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [NUM_CH-1:0] sync1_q, sync2_q, hist_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [7:0]        score_q, score_d;
  logic [3:0]        lives_q, lives_d;
  logic [SYM_W-1:0]  mem_q [MAX_LEN];
  logic              mem_we;
  logic              restart;

  logic              tick;
  logic              last;
  logic [NUM_CH-1:0] edges;
  logic [NUM_CH-1:0] sym_mask;
  logic [SYM_W-1:0]  cur_sym;
  logic              press;
  logic              hit;

  assign tick     = (cnt_q == CntW'(TICK_DIV - 1));
  assign last     = (LenW'(idx_q) == len_q - LenW'(1));
  assign edges    = sync2_q & ~hist_q;
  assign cur_sym  = mem_q[idx_q];
  assign sym_mask = NUM_CH'(1) << cur_sym;
  assign press    = |edges;
  // Exactly one rising edge, on the expected channel; any multi-edge cycle fails this.
  assign hit      = (edges == sym_mask);

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Two-flop synchroniser plus edge history; history runs in every state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= user_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Sequence storage; one symbol appended per EXTEND, contents never need clearing
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[len_q[IdxW-1:0]] <= lfsr_q[SYM_W-1:0];
    end
  end

  // Game state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      to_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      score_q <= '0;
      lives_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

  // Next-state logic for the game FSM, tick counter and timeout counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    score_d = score_q;
    lives_d = lives_q;
    to_d    = to_q;
    mem_we  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      StIdle, StOver, StWin: begin
        if (start) begin
          state_d = StExtend;
          lives_d = 4'(LIVES);
          score_d = '0;
          len_d   = '0;
        end
      end
      StExtend: begin
        mem_we  = 1'b1;
        len_d   = len_q + LenW'(1);
        idx_d   = '0;
        state_d = StShowOn;
      end
      StShowOn: begin
        if (tick) state_d = StShowOff;
      end
      StShowOff: begin
        if (tick) begin
          if (last) begin
            idx_d   = '0;
            state_d = StInput;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StShowOn;
          end
        end
      end
      StInput: begin
        if (press) begin
          if (!hit) begin
            state_d = StMiss;
          end else if (last) begin
            state_d = StRoundOk;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            restart = 1'b1;
          end
        end else if (tick) begin
          if (to_q == ToW'(TIMEOUT_TICKS - 1)) state_d = StMiss;
          else to_d = to_q + ToW'(1);
        end
      end
      StRoundOk: begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        state_d = (len_q == LenW'(MAX_LEN)) ? StWin : StExtend;
      end
      StMiss: begin
        lives_d = lives_q - 4'd1;
        if (lives_q == 4'd1) begin
          state_d = StOver;
        end else begin
          // Replay the same sequence without extending it
          idx_d   = '0;
          state_d = StShowOn;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) restart = 1'b1;
    if (restart) to_d = '0;
    cnt_d = (restart || tick) ? '0 : cnt_q + CntW'(1);
  end

  // Outputs decoded from registered state
  always_comb begin
    disp_valid = (state_q == StShowOn);
    disp_sym   = disp_valid ? cur_sym : '0;
    score      = score_q;
    lives      = lives_q;
    busy       = !(state_q inside {StIdle, StOver, StWin});
    game_over  = (state_q == StOver);
    win        = (state_q == StWin);
  end

endmodule
